// File: rtl/wbutxuart.sv
// 8N1/8N2 UART transmitter with optional CTS; frame starts the clock after accept.
// o_busy holds off the next byte until the last stop-bit clock (gap-free frames when i_stb is held).
module wbutxuart #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd868,
  parameter int          NSTOP           = 1,
  parameter int          HW_FLOW         = 0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_stb,
  input  logic [7:0] i_data,
  output logic       o_busy,
  input  logic       i_cts_n,
  output logic       o_uart_tx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [23:0] BAUD_RELOAD = CLOCKS_PER_BAUD - 24'd1;
  localparam logic [3:0]  LAST_STOP   = 4'(NSTOP - 1);

  state_t      state;
  logic [23:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  sreg;
  logic        frame_busy;
  logic        cts_s1;
  logic        cts_s2;
  logic        accept;

  // CTS only gates new accepts; it never reaches an in-flight frame.
  assign o_busy = frame_busy | ((HW_FLOW != 0) && cts_s2);
  assign accept = i_stb && !o_busy;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cts_s1 <= 1'b1;
      cts_s2 <= 1'b1;
    end else begin
      cts_s1 <= i_cts_n;
      cts_s2 <= cts_s1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      o_uart_tx  <= 1'b1;
      frame_busy <= 1'b0;
      baud_cnt   <= 24'd0;
      bit_cnt    <= 4'd0;
      sreg       <= 8'hff;
    end else begin
      case (state)
        IDLE: begin
          o_uart_tx <= 1'b1;
          if (accept) begin
            state      <= START;
            o_uart_tx  <= 1'b0;
            sreg       <= i_data;
            baud_cnt   <= BAUD_RELOAD;
            bit_cnt    <= 4'd0;
            frame_busy <= 1'b1;
          end
        end
        START: begin
          if (baud_cnt != 24'd0) begin
            baud_cnt <= baud_cnt - 24'd1;
          end else begin
            state     <= DATA;
            o_uart_tx <= sreg[0];
            sreg      <= {1'b1, sreg[7:1]};
            baud_cnt  <= BAUD_RELOAD;
            bit_cnt   <= 4'd0;
          end
        end
        DATA: begin
          if (baud_cnt != 24'd0) begin
            baud_cnt <= baud_cnt - 24'd1;
          end else begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt == 4'd7) begin
              state     <= STOP;
              o_uart_tx <= 1'b1;
              bit_cnt   <= 4'd0;
            end else begin
              o_uart_tx <= sreg[0];
              sreg      <= {1'b1, sreg[7:1]};
              bit_cnt   <= bit_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          if (baud_cnt != 24'd0) begin
            baud_cnt <= baud_cnt - 24'd1;
            // Release one clock early so a held strobe lands on the final stop clock.
            if (baud_cnt == 24'd1 && bit_cnt == LAST_STOP)
              frame_busy <= 1'b0;
          end else if (bit_cnt != LAST_STOP) begin
            bit_cnt  <= bit_cnt + 4'd1;
            baud_cnt <= BAUD_RELOAD;
          end else if (accept) begin
            state      <= START;
            o_uart_tx  <= 1'b0;
            sreg       <= i_data;
            baud_cnt   <= BAUD_RELOAD;
            bit_cnt    <= 4'd0;
            frame_busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
